sdram_read_fifo: RTL and testbench

//  - Buffers 32-bit words from the SDRAM read engine (fifo_data/fifo_wr/fifo_full) for the wishbone side.
//  - Drives fifo_full early, FULL_MARGIN words before true full, so in-flight words still land.
//  - Registered read port; single clock domain (the SDRAM clock).

---
 rtl/sdram_read_fifo_if.sv | 28 ++
 rtl/sdram_read_fifo.sv | 116 +++++++++++
 tb/tb_sdram_read_fifo.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/sdram_read_fifo_if.sv
// Handshake bundle between the SDRAM read engine, the read FIFO and its consumer.
// The master modport is the engine/consumer side; the slave modport is the FIFO.
interface sdram_read_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_wr;
  logic                  fifo_full;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  flush;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output fifo_data, fifo_wr, rd_en, flush,
    input  fifo_full, rd_data, rd_valid, empty, count, overflow, underflow
  );

  modport slave (
    input  fifo_data, fifo_wr, rd_en, flush,
    output fifo_full, rd_data, rd_valid, empty, count, overflow, underflow
  );
endinterface

// File: rtl/sdram_read_fifo.sv
// SDRAM read-data FIFO: buffers words from the SDRAM read engine for the wishbone side.
// fifo_full is raised FULL_MARGIN words early so words already in flight still land;
// the true capacity check (count == DEPTH) is what actually drops writes.
// Read port is registered: rd_data/rd_valid appear one clock after an accepted pop.
// Optional sticky overflow/underflow flags are built when SDRAM_RD_FIFO_ERR_EN is defined;
// otherwise both outputs are tied low and the port list is unchanged.
module sdram_read_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 4,
  parameter int FULL_MARGIN = 2
) (
  input logic              clk,
  input logic              rst,
  sdram_read_fifo_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH+1)'(DEPTH - FULL_MARGIN);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  empty_q;
  logic                  full_q;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  wr_acc;
  logic                  rd_acc;

  // Accept/reject both sides from the count held at the start of the cycle; flush wins.
  always_comb begin
    wr_acc = bus.fifo_wr & (count_q != DEPTH_CNT) & ~bus.flush;
    rd_acc = bus.rd_en & (count_q != '0) & ~bus.flush;
    if (bus.flush) begin
      count_next = '0;
    end else begin
      count_next = count_q + (ADDR_WIDTH+1)'(wr_acc) - (ADDR_WIDTH+1)'(rd_acc);
    end
  end

  // Storage array: data only, no reset needed since pointers/count define validity.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= bus.fifo_data;
    end
  end

  // Pointers, occupancy, registered flags and the registered read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      count_q    <= count_next;
      empty_q    <= (count_next == '0);
      full_q     <= (count_next >= FULL_LEVEL);
      rd_valid_q <= rd_acc;
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) begin
          wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
        end
        if (rd_acc) begin
          rd_ptr    <= rd_ptr + ADDR_WIDTH'(1);
          rd_data_q <= mem[rd_ptr];
        end
      end
    end
  end

`ifdef SDRAM_RD_FIFO_ERR_EN
  logic overflow_q;
  logic underflow_q;

  // Sticky error flags: set on a dropped write or a pop on empty, cleared by rst or flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.flush) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.fifo_wr && (count_q == DEPTH_CNT)) begin
        overflow_q <= 1'b1;
      end
      if (bus.rd_en && (count_q == '0)) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

  assign bus.count     = count_q;
  assign bus.empty     = empty_q;
  assign bus.fifo_full = full_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;

endmodule

// File: tb/tb_sdram_read_fifo.sv
// Testbench for sdram_read_fifo: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based reference model of the FIFO.
module tb_sdram_read_fifo;

  localparam int DATA_WIDTH  = 32;
  localparam int ADDR_WIDTH  = 4;
  localparam int FULL_MARGIN = 2;
  localparam int DEPTH       = 16;
`ifdef SDRAM_RD_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sdram_read_fifo_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  sdram_read_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .FULL_MARGIN(FULL_MARGIN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference model state
  logic [31:0] m_q[$];
  logic [31:0] m_rd_data;
  bit          m_rd_valid;
  bit          m_ovf;
  bit          m_udf;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rd_data  = '0;
    m_rd_valid = 1'b0;
    m_ovf      = 1'b0;
    m_udf      = 1'b0;
  endtask

  task automatic model_step(input bit wr, input logic [31:0] d, input bit rd, input bit fl);
    int pre;
    pre = m_q.size();
    if (fl) begin
      m_q.delete();
      m_rd_valid = 1'b0;
      m_ovf      = 1'b0;
      m_udf      = 1'b0;
    end else begin
      m_rd_valid = (rd && pre > 0);
      if (m_rd_valid) m_rd_data = m_q.pop_front();
      if (wr && pre < DEPTH) m_q.push_back(d);
      if (ERR_EN && wr && pre == DEPTH) m_ovf = 1'b1;
      if (ERR_EN && rd && pre == 0) m_udf = 1'b1;
    end
  endtask

  task automatic check_outputs();
    int n;
    n = m_q.size();
    check("count",     64'(bus.count),     64'(n));
    check("empty",     64'(bus.empty),     64'(n == 0));
    check("fifo_full", 64'(bus.fifo_full), 64'(n >= DEPTH - FULL_MARGIN));
    check("rd_valid",  64'(bus.rd_valid),  64'(m_rd_valid));
    check("rd_data",   64'(bus.rd_data),   64'(m_rd_data));
    check("overflow",  64'(bus.overflow),  64'(m_ovf));
    check("underflow", 64'(bus.underflow), 64'(m_udf));
  endtask

  // One clock: drive inputs, take the edge, update model, then sample 1 time unit later.
  task automatic step(input bit wr, input logic [31:0] d, input bit rd, input bit fl);
    bus.fifo_wr   = wr;
    bus.fifo_data = d;
    bus.rd_en     = rd;
    bus.flush     = fl;
    @(posedge clk);
    model_step(wr, d, rd, fl);
    #1;
    bus.fifo_wr = 1'b0;
    bus.rd_en   = 1'b0;
    bus.flush   = 1'b0;
    check_outputs();
  endtask

  // Assert rst between edges and check that outputs clear with no clock edge.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    bus.fifo_data = '0;
    bus.fifo_wr   = 1'b0;
    bus.rd_en     = 1'b0;
    bus.flush     = 1'b0;

    // 1: reset from power-up, then again mid-traffic
    async_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 32'hDEAD_0000 + 32'(i), 1'b0, 1'b0);
    async_reset();
    check("rst_count_zero", 64'(bus.count), 64'(0));

    // 2: fill 0x0..0xF, early full after the 14th word, 17th write dropped
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 32'(i), 1'b0, 1'b0);
      if (i == 12) check("fill_full_13", 64'(bus.fifo_full), 64'(0));
      if (i == 13) check("fill_full_14", 64'(bus.fifo_full), 64'(1));
    end
    check("fill_count16", 64'(bus.count), 64'(16));
    step(1'b1, 32'h1111_1111, 1'b0, 1'b0);
    check("fill_drop17", 64'(bus.count), 64'(16));

    // 3: drain with rd_en held for 17 cycles
    for (int i = 0; i < 17; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      if (i < DEPTH) check("drain_order", 64'(bus.rd_data), 64'(i));
    end
    check("drain_empty", 64'(bus.empty), 64'(1));

    // 4: streaming at count 8 across pointer wrap
    for (int i = 0; i < 8; i++) step(1'b1, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, $urandom, 1'b1, 1'b0);
    check("stream_count8", 64'(bus.count), 64'(8));

    // 5: edges at count 0 and count 16
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 32'h0BAD_F00D, 1'b1, 1'b0);
    check("edge0_count", 64'(bus.count), 64'(1));
    check("edge0_rdv",   64'(bus.rd_valid), 64'(0));
    for (int i = 0; i < 15; i++) step(1'b1, $urandom, 1'b0, 1'b0);
    step(1'b1, 32'hFFFF_0000, 1'b1, 1'b0);
    check("edge16_count", 64'(bus.count), 64'(15));
    check("edge16_pop",   64'(bus.rd_data), 64'(32'h0BAD_F00D));

    // 6: flush at count 5 with wr+rd in the same cycle
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 32'h7777_7777, 1'b1, 1'b1);
    check("flush_count", 64'(bus.count), 64'(0));
    check("flush_ovf",   64'(bus.overflow), 64'(0));
    check("flush_udf",   64'(bus.underflow), 64'(0));
    step(1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("flush_a5", 64'(bus.rd_data), 64'(32'hA5A5_A5A5));

    // Randomized traffic with shifting write/read bias to visit full and empty
    for (int blk = 0; blk < 6; blk++) begin
      int wr_pct;
      int rd_pct;
      wr_pct = (blk % 3 == 0) ? 85 : (blk % 3 == 1) ? 20 : 50;
      rd_pct = (blk % 3 == 0) ? 25 : (blk % 3 == 1) ? 85 : 50;
      for (int c = 0; c < 80; c++) begin
        step($urandom_range(99) < wr_pct, $urandom, $urandom_range(99) < rd_pct,
             $urandom_range(99) < 2);
      end
      if (blk == 3) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
